// File: rtl/window_generator_if.sv
// Pixel-in / 3x3-window-out stream bundle for window_generator.
// The slave view is the window generator itself; the master view is its environment.
interface window_generator_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] line0_data0, line0_data1, line0_data2;
  logic [DATA_WIDTH-1:0] line1_data0, line1_data1, line1_data2;
  logic [DATA_WIDTH-1:0] line2_data0, line2_data1, line2_data2;
  logic [3:0]            corner_type;
  logic                  out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_last, corner_type,
    output line0_data0, line0_data1, line0_data2,
    output line1_data0, line1_data1, line1_data2,
    output line2_data0, line2_data1, line2_data2
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_last, corner_type,
    input  line0_data0, line0_data1, line0_data2,
    input  line1_data0, line1_data1, line1_data2,
    input  line2_data0, line2_data1, line2_data2
  );
endinterface

// File: rtl/window_generator.sv
// Streaming 3x3 window generator: two line buffers plus a shift window, with
// zero-filled borders and a corner_type code per emitted window.
module window_generator #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst,
  window_generator_if.slave  bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(IMG_WIDTH + 2);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] C_PEN  = CW'(IMG_WIDTH - 2);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] R_PEN  = RW'(IMG_HEIGHT - 2);
  localparam logic [FW-1:0] F_LAST = FW'(IMG_WIDTH);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  typedef logic [DATA_WIDTH-1:0] pix_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] row_q, row_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [3:0]    corner_q, corner_d;
  pix_t          win_q [3][3];
  pix_t          win_d [3][3];
  pix_t          raw_q [3][2];
  pix_t          raw_d [3][2];
  pix_t          lb0_q [IMG_WIDTH];
  pix_t          lb1_q [IMG_WIDTH];
  pix_t          shift_in, lb0_rd, lb1_rd;
  pix_t          pre   [3][3];
  logic          step, in_ready;

  // Border masking: line k holds row r+1-k, data j holds column c+1-j.
  function automatic logic keep_pixel(input int k, input int j,
                                      input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic keep;
    keep = 1'b1;
    if (k == 2 && r == '0)     keep = 1'b0;
    if (k == 0 && r == R_LAST) keep = 1'b0;
    if (j == 2 && c == '0)     keep = 1'b0;
    if (j == 0 && c == C_LAST) keep = 1'b0;
    return keep;
  endfunction

  function automatic logic [3:0] corner_code(input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic [3:0] code;
    if (c == '0) begin
      if (r == '0)          code = 4'd1;
      else if (r == R_LAST) code = 4'd5;
      else                  code = 4'd3;
    end else if (c == C_LAST) begin
      if (r == '0)          code = 4'd2;
      else if (r == R_LAST) code = 4'd6;
      else                  code = 4'd4;
    end else begin
      code = 4'd8;
    end
    return code;
  endfunction

  always_comb begin
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        step     = bus.in_valid;
      end
      RUN: begin
        in_ready = !out_valid_q || bus.out_ready;
        step     = bus.in_valid && in_ready;
      end
      default: begin
        in_ready = 1'b0;
        step     = !out_valid_q || bus.out_ready;
      end
    endcase
  end

  // Datapath: new column enters at data0, older columns slide toward data2.
  always_comb begin
    shift_in = (state_q == FLUSH) ? '0 : bus.in_data;
    lb0_rd   = lb0_q[ptr_q];
    lb1_rd   = lb1_q[ptr_q];
    pre[0][0] = shift_in;
    pre[1][0] = lb0_rd;
    pre[2][0] = lb1_rd;
    for (int k = 0; k < 3; k++) begin
      pre[k][1]   = raw_q[k][0];
      pre[k][2]   = raw_q[k][1];
      raw_d[k][0] = pre[k][0];
      raw_d[k][1] = pre[k][1];
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_last_d  = out_last_q && !bus.out_ready;
    corner_d    = out_valid_d ? corner_q : 4'd0;
    win_d       = win_q;
    if (step) begin
      ptr_d = (ptr_q == C_LAST) ? '0 : ptr_q + 1'b1;
      if (state_q == FILL) begin
        fill_d = fill_q + 1'b1;
        if (fill_q == F_LAST) begin
          state_d = RUN;
          fill_d  = '0;
        end
      end else begin
        out_valid_d = 1'b1;
        out_last_d  = (row_q == R_LAST) && (col_q == C_LAST);
        corner_d    = corner_code(row_q, col_q);
        for (int k = 0; k < 3; k++) begin
          for (int j = 0; j < 3; j++) begin
            win_d[k][j] = keep_pixel(k, j, row_q, col_q) ? pre[k][j] : '0;
          end
        end
        if (col_q == C_LAST) begin
          col_d = '0;
          row_d = (row_q == R_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        // Last input pixel is accepted while emitting (H-2, W-2).
        if (state_q == RUN && row_q == R_PEN && col_q == C_PEN)
          state_d = FLUSH;
        if (state_q == FLUSH && row_q == R_LAST && col_q == C_LAST)
          state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      ptr_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      corner_q    <= 4'd0;
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 3; j++)
          win_q[k][j] <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ptr_q       <= ptr_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      corner_q    <= corner_d;
      win_q       <= win_d;
    end
  end

  // Line buffers and the unmasked shift columns carry no reset.
  always_ff @(posedge clk) begin
    if (step) begin
      lb0_q[ptr_q] <= shift_in;
      lb1_q[ptr_q] <= lb0_rd;
      raw_q        <= raw_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_last    = out_last_q;
  assign bus.corner_type = corner_q;
  assign bus.line0_data0 = win_q[0][0];
  assign bus.line0_data1 = win_q[0][1];
  assign bus.line0_data2 = win_q[0][2];
  assign bus.line1_data0 = win_q[1][0];
  assign bus.line1_data1 = win_q[1][1];
  assign bus.line1_data2 = win_q[1][2];
  assign bus.line2_data0 = win_q[2][0];
  assign bus.line2_data1 = win_q[2][1];
  assign bus.line2_data2 = win_q[2][2];
endmodule

// File: tb/tb_window_generator.sv
// Bench for window_generator with a 4x3 image: fixed vectors, backpressure,
// bubbles, back-to-back frames, mid-frame reset and random traffic.
module tb_window_generator;
  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  typedef struct packed {
    logic [3:0]         ct;
    logic               last;
    logic [8:0][DW-1:0] px;
  } win_t;

  typedef struct {
    int   idx;
    win_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_generator_if #(.DATA_WIDTH(DW)) bus ();
  window_generator #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] stim[$];
  win_t          got[$];
  int            vmode = 0;
  int            rmode = 0;
  int            bp_at = -1;
  int            busy_low;
  vec_t          tbl[9];

  function automatic win_t read_out();
    win_t w;
    w.ct    = bus.corner_type;
    w.last  = bus.out_last;
    w.px[0] = bus.line0_data0; w.px[1] = bus.line0_data1; w.px[2] = bus.line0_data2;
    w.px[3] = bus.line1_data0; w.px[4] = bus.line1_data1; w.px[5] = bus.line1_data2;
    w.px[6] = bus.line2_data0; w.px[7] = bus.line2_data1; w.px[8] = bus.line2_data2;
    return w;
  endfunction

  function automatic win_t mk(int ct, bit last, int a0, int a1, int a2,
                              int b0, int b1, int b2, int c0, int c1, int c2);
    win_t w;
    w.ct = 4'(ct);
    w.last = last;
    w.px[0] = DW'(a0); w.px[1] = DW'(a1); w.px[2] = DW'(a2);
    w.px[3] = DW'(b0); w.px[4] = DW'(b1); w.px[5] = DW'(b2);
    w.px[6] = DW'(c0); w.px[7] = DW'(c1); w.px[8] = DW'(c2);
    return w;
  endfunction

  // Reference: neighbour (r+1-k, c+1-j) of the frame starting at stim[base], zero outside.
  function automatic win_t model(int base, int n);
    win_t w;
    int r, c, rr, cc;
    r = n / W;
    c = n % W;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        rr = r + 1 - k;
        cc = c + 1 - j;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W) w.px[k*3+j] = stim[base + rr*W + cc];
        else                                        w.px[k*3+j] = '0;
      end
    end
    if (r == 0 && c == 0)            w.ct = 4'd1;
    else if (r == 0 && c == W-1)     w.ct = 4'd2;
    else if (r == H-1 && c == 0)     w.ct = 4'd5;
    else if (r == H-1 && c == W-1)   w.ct = 4'd6;
    else if (c == 0)                 w.ct = 4'd3;
    else if (c == W-1)               w.ct = 4'd4;
    else                             w.ct = 4'd8;
    w.last = (n == NPIX - 1);
    return w;
  endfunction

  function automatic void check_win(string name, win_t a, win_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got ct=%0d last=%0b px=%h, want ct=%0d last=%0b px=%h",
               name, a.ct, a.last, a.px, e.ct, e.last, e.px);
    end
  endfunction

  function automatic void check_int(string name, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, a, e);
    end
  endfunction

  // Runs from #1 after a posedge until nwin windows are accepted or the budget expires.
  task automatic run(input int nwin, input int budget);
    int   sent, cyc, stall;
    logic iv, ordy, stall_chk;
    win_t snap;
    sent = 0; cyc = 0; stall = 0; busy_low = 0;
    snap = '0;
    got.delete();
    while (got.size() < nwin && cyc < budget) begin
      iv = (sent < stim.size());
      if (vmode == 1)      iv = iv && (cyc % 2 == 0);
      else if (vmode == 2) iv = iv && ($urandom_range(0, 2) != 0);
      ordy = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      stall_chk = 1'b0;
      if (bp_at >= 0 && stall < 3 && (stall > 0 || (bus.out_valid && got.size() == bp_at))) begin
        if (stall == 0) snap = read_out();
        ordy = 1'b0;
        stall++;
        stall_chk = 1'b1;
      end
      bus.in_valid  = iv;
      bus.in_data   = iv ? stim[sent] : '0;
      bus.out_ready = ordy;
      @(negedge clk);
      if (stall_chk) begin
        check_win($sformatf("bp_hold_%0d", stall), read_out(), snap);
        check_int($sformatf("bp_valid_%0d", stall), int'(bus.out_valid), 1);
        check_int($sformatf("bp_in_ready_%0d", stall), int'(bus.in_ready), 0);
      end
      if (iv && !bus.in_ready) busy_low++;
      if (bus.out_valid && ordy) got.push_back(read_out());
      if (iv && bus.in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (got.size() < nwin) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: got %0d windows, want %0d", got.size(), nwin);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic verify(input int nf, input string name);
    check_int({name, "_count"}, got.size(), nf * NPIX);
    for (int i = 0; i < got.size() && i < nf * NPIX; i++)
      check_win($sformatf("%s_win%0d", name, i), got[i], model((i / NPIX) * NPIX, i % NPIX));
  endtask

  task automatic check_zero_outputs(input string name);
    check_int({name, "_valid"}, int'(bus.out_valid), 0);
    check_win({name, "_win"}, read_out(), '0);
  endtask

  task automatic load_seq(input int first);
    stim.delete();
    for (int i = 0; i < NPIX; i++) stim.push_back(DW'(first + i));
  endtask

  initial begin
    int acc, cyc;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;

    tbl[0] = '{idx: 0,  exp: mk(1, 0,  6,  5,  0,   2,  1,  0,   0, 0, 0)};
    tbl[1] = '{idx: 5,  exp: mk(8, 0, 11, 10,  9,   7,  6,  5,   3, 2, 1)};
    tbl[2] = '{idx: 11, exp: mk(6, 1,  0,  0,  0,   0, 12, 11,   0, 8, 7)};
    tbl[3] = '{idx: 3,  exp: mk(2, 0,  0,  8,  7,   0,  4,  3,   0, 0, 0)};
    tbl[4] = '{idx: 4,  exp: mk(3, 0, 10,  9,  0,   6,  5,  0,   2, 1, 0)};
    tbl[5] = '{idx: 7,  exp: mk(4, 0,  0, 12, 11,   0,  8,  7,   0, 4, 3)};
    tbl[6] = '{idx: 8,  exp: mk(5, 0,  0,  0,  0,  10,  9,  0,   6, 5, 0)};
    tbl[7] = '{idx: 1,  exp: mk(8, 0,  7,  6,  5,   3,  2,  1,   0, 0, 0)};
    tbl[8] = '{idx: 9,  exp: mk(8, 0,  0,  0,  0,  11, 10,  9,   7, 6, 5)};

    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_int("reset_in_ready", int'(bus.in_ready), 1);

    load_seq(1);
    run(NPIX, 200);
    verify(1, "basic");
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].idx < got.size())
        check_win($sformatf("tbl_win%0d", tbl[i].idx), got[tbl[i].idx], tbl[i].exp);
      else
        check_int($sformatf("tbl_missing%0d", tbl[i].idx), got.size(), tbl[i].idx + 1);
    end

    bp_at = 5;
    run(NPIX, 200);
    verify(1, "bp");
    bp_at = -1;

    vmode = 1;
    run(NPIX, 300);
    verify(1, "bubble");
    vmode = 0;

    load_seq(1);
    for (int i = 0; i < NPIX; i++) stim.push_back(DW'(101 + i));
    run(2 * NPIX, 400);
    verify(2, "b2b");
    check_int("b2b_flush_busy", busy_low, W + 1);
    if (got.size() > NPIX) check_int("b2b_f2_centre", int'(got[NPIX].px[4]), 101);

    load_seq(1);
    acc = 0;
    cyc = 0;
    while (acc < 7 && cyc < 50) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = stim[acc];
      bus.out_ready = 1'b1;
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_int("midrst_accepts", acc, 7);
    check_int("midrst_pre_valid", int'(bus.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("midrst_async");
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_int("midrst_in_ready", int'(bus.in_ready), 1);
    run(NPIX, 200);
    verify(1, "postrst");

    vmode = 2;
    rmode = 1;
    for (int t = 0; t < 2; t++) begin
      stim.delete();
      for (int i = 0; i < 3 * NPIX; i++) stim.push_back(DW'($urandom_range(0, 255)));
      run(3 * NPIX, 3000);
      verify(3, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
